// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 32-bit, 16-register pipelined processor.
//   DATA_W       operand/result width
//   REG_AW       register index width (16 registers)
//   OP_W         ALU opcode width
//   REG_PROT_LO  first register whose writes the register file discards
//   REG_PROT_HI  last register whose writes the register file discards
//   alu_op_e     ALU opcode encoding carried down the pipeline
//   is_hazardable() true for registers that can carry a RAW dependency
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 4;
    localparam int OP_W   = 4;

    localparam logic [REG_AW-1:0] REG_PROT_LO = 4'd14;
    localparam logic [REG_AW-1:0] REG_PROT_HI = 4'd15;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_LUI   = 4'd10,
        ALU_PASSB = 4'd11
    } alu_op_e;

    // Writes to the protected range never reach the register file, so a
    // producer targeting them can never create a dependency.
    function automatic logic is_hazardable(input logic [REG_AW-1:0] idx);
        return !((idx >= REG_PROT_LO) && (idx <= REG_PROT_HI));
    endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// -----------------------------------------------------------------------------
// operand_fwd_mux
// Selects the value of one source operand for the instruction in ID, taking
// the youngest in-flight producer of that register.
//   rs_i, use_i         source index and whether the instruction reads it
//   rf_data_i           value read from the register file
//   ex_valid_i, ex_rd_we_i, ex_is_load_i, ex_rd_i, alu_result_i
//                       instruction currently in EX and its ALU result
//   mem_valid_i, mem_rd_we_i, mem_rd_i, mem_result_i
//                       instruction currently in MEM and its writeback value
//   operand_o           selected operand value
// -----------------------------------------------------------------------------
module operand_fwd_mux
    import cpu_pkg::*;
(
    input  logic [REG_AW-1:0] rs_i,
    input  logic              use_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic              ex_valid_i,
    input  logic              ex_rd_we_i,
    input  logic              ex_is_load_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              mem_valid_i,
    input  logic              mem_rd_we_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic [DATA_W-1:0] mem_result_i,
    output logic [DATA_W-1:0] operand_o
);

    logic fwd_enable;
    logic ex_match;
    logic mem_match;

    // A load in EX has no data yet; that case is handled by the load-use
    // bubble, so only non-load EX producers are forwarded here.
    assign fwd_enable = use_i & is_hazardable(rs_i);
    assign ex_match   = fwd_enable & ex_valid_i & ex_rd_we_i & ~ex_is_load_i
                        & (ex_rd_i == rs_i);
    assign mem_match  = fwd_enable & mem_valid_i & mem_rd_we_i
                        & (mem_rd_i == rs_i);

    // EX is younger than MEM, so it wins when both write the same register.
    always_comb begin
        operand_o = rf_data_i;
        if (ex_match) begin
            operand_o = alu_result_i;
        end else if (mem_match) begin
            operand_o = mem_result_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// Decode-to-execute stage: forwards operands from EX/MEM, detects load-use
// hazards and holds the ID/EX pipeline register feeding the ALU.
//   clk, reset                     clock, synchronous active-high reset
//   id_*                           instruction currently in ID
//   rf_rdata1, rf_rdata2           register file read data for id_rs1/id_rs2
//   alu_result                     EX result of the instruction held here
//   mem_valid, mem_rd_we, mem_rd, mem_result   MEM-stage writeback candidate
//   flush                          kill the ID instruction
//   ex_hold                        downstream stall, freeze ID/EX
//   stall                          freeze PC and IF/ID
//   ex_*                           ID/EX register contents
//   stall_cnt                      saturating count of load-use bubbles
// -----------------------------------------------------------------------------
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rd_we,
    input  logic              id_is_load,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [OP_W-1:0]   id_alu_op,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              mem_valid,
    input  logic              mem_rd_we,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_rd_we,
    output logic              ex_is_load,
    output logic [REG_AW-1:0] ex_rd,
    output logic [OP_W-1:0]   ex_alu_op,
    output logic [DATA_W-1:0] ex_op_a,
    output logic [DATA_W-1:0] ex_op_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [15:0]       stall_cnt
);

    logic              ex_valid_q,   ex_valid_d;
    logic              ex_rd_we_q,   ex_rd_we_d;
    logic              ex_is_load_q, ex_is_load_d;
    logic [REG_AW-1:0] ex_rd_q,      ex_rd_d;
    logic [OP_W-1:0]   ex_alu_op_q,  ex_alu_op_d;
    logic [DATA_W-1:0] ex_op_a_q,    ex_op_a_d;
    logic [DATA_W-1:0] ex_op_b_q,    ex_op_b_d;
    logic [DATA_W-1:0] ex_imm_q,     ex_imm_d;
    logic [15:0]       stall_cnt_q,  stall_cnt_d;

    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic              load_use;

    operand_fwd_mux u_fwd_a (
        .rs_i         (id_rs1),
        .use_i        (id_use_rs1),
        .rf_data_i    (rf_rdata1),
        .ex_valid_i   (ex_valid_q),
        .ex_rd_we_i   (ex_rd_we_q),
        .ex_is_load_i (ex_is_load_q),
        .ex_rd_i      (ex_rd_q),
        .alu_result_i (alu_result),
        .mem_valid_i  (mem_valid),
        .mem_rd_we_i  (mem_rd_we),
        .mem_rd_i     (mem_rd),
        .mem_result_i (mem_result),
        .operand_o    (fwd_a)
    );

    operand_fwd_mux u_fwd_b (
        .rs_i         (id_rs2),
        .use_i        (id_use_rs2),
        .rf_data_i    (rf_rdata2),
        .ex_valid_i   (ex_valid_q),
        .ex_rd_we_i   (ex_rd_we_q),
        .ex_is_load_i (ex_is_load_q),
        .ex_rd_i      (ex_rd_q),
        .alu_result_i (alu_result),
        .mem_valid_i  (mem_valid),
        .mem_rd_we_i  (mem_rd_we),
        .mem_rd_i     (mem_rd),
        .mem_result_i (mem_result),
        .operand_o    (fwd_b)
    );

    // A load in EX only produces its data in MEM, so a dependent instruction
    // in ID must wait one cycle and then pick the value up from MEM.
    assign load_use = id_valid & ex_valid_q & ex_is_load_q & ex_rd_we_q
                      & is_hazardable(ex_rd_q)
                      & ((id_use_rs1 & (ex_rd_q == id_rs1))
                       | (id_use_rs2 & (ex_rd_q == id_rs2)));

    // A flushed instruction never needs its operands, and during reset the
    // held EX contents are meaningless, so neither can raise a load-use stall.
    assign stall = ex_hold | (load_use & ~flush & ~reset);

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_rd_we_d   = ex_rd_we_q;
        ex_is_load_d = ex_is_load_q;
        ex_rd_d      = ex_rd_q;
        ex_alu_op_d  = ex_alu_op_q;
        ex_op_a_d    = ex_op_a_q;
        ex_op_b_d    = ex_op_b_q;
        ex_imm_d     = ex_imm_q;
        stall_cnt_d  = stall_cnt_q;

        // Flush beats hold: the killed instruction must not survive a freeze.
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (ex_hold) begin
            ex_valid_d = ex_valid_q;
        end else if (load_use) begin
            ex_valid_d = 1'b0;
            if (stall_cnt_q != 16'hFFFF) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end else begin
            ex_valid_d   = id_valid;
            ex_rd_we_d   = id_rd_we;
            ex_is_load_d = id_is_load;
            ex_rd_d      = id_rd;
            ex_alu_op_d  = id_alu_op;
            ex_op_a_d    = fwd_a;
            ex_op_b_d    = fwd_b;
            ex_imm_d     = id_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q   <= 1'b0;
            ex_rd_we_q   <= 1'b0;
            ex_is_load_q <= 1'b0;
            ex_rd_q      <= '0;
            ex_alu_op_q  <= '0;
            ex_op_a_q    <= '0;
            ex_op_b_q    <= '0;
            ex_imm_q     <= '0;
            stall_cnt_q  <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_rd_we_q   <= ex_rd_we_d;
            ex_is_load_q <= ex_is_load_d;
            ex_rd_q      <= ex_rd_d;
            ex_alu_op_q  <= ex_alu_op_d;
            ex_op_a_q    <= ex_op_a_d;
            ex_op_b_q    <= ex_op_b_d;
            ex_imm_q     <= ex_imm_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_rd_we   = ex_rd_we_q;
    assign ex_is_load = ex_is_load_q;
    assign ex_rd      = ex_rd_q;
    assign ex_alu_op  = ex_alu_op_q;
    assign ex_op_a    = ex_op_a_q;
    assign ex_op_b    = ex_op_b_q;
    assign ex_imm     = ex_imm_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage of the 32-bit, 16-register pipelined processor. It captures the two operands read asynchronously from the register file, resolves RAW hazards by forwarding from the EX and MEM stages, and inserts a one-cycle bubble on load-use hazards. It holds the ID/EX pipeline register that feeds the ALU, and honours flush and hold requests.

## Interface
- DATA_W, 32, operand/result width
- REG_AW, 4, register index width (16 registers)
- OP_W, 4, ALU opcode width
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- id_valid  in  1  valid instruction in ID
- id_rs1, id_rs2  in  REG_AW  source indices, also driven to the register file read ports
- id_use_rs1, id_use_rs2  in  1  instruction actually reads that source
- id_rd  in  REG_AW  destination index
- id_rd_we, id_is_load  in  1  writes rd; is a load
- id_imm  in  DATA_W  immediate; id_alu_op  in  OP_W
- rf_rdata1, rf_rdata2  in  DATA_W  register file read data
- alu_result  in  DATA_W  combinational EX-stage result of the instruction held in this block
- mem_valid, mem_rd_we  in  1 ; mem_rd  in  REG_AW ; mem_result  in  DATA_W  MEM-stage writeback candidate, load data included
- flush  in  1  kill the ID instruction (taken branch)
- ex_hold  in  1  downstream stall; freeze the ID/EX register
- stall  out  1  freeze PC and IF/ID
- ex_valid, ex_rd_we, ex_is_load  out  1 ; ex_rd  out  REG_AW ; ex_alu_op  out  OP_W ; ex_op_a, ex_op_b, ex_imm  out  DATA_W
- stall_cnt  out  16  saturating count of load-use bubbles

## Operation
- Hazardable register: index < 14. R14/R15 writes are discarded by the register file, so they are never forwarded and never stall.
- Forward select per source (only when use bit set, index hazardable), priority order:
  - EX: ex_valid & ex_rd_we & !ex_is_load & ex_rd==rs -> alu_result
  - MEM: mem_valid & mem_rd_we & mem_rd==rs -> mem_result
  - else the register file data
- No WB forwarding is needed. WB writes the register file on the falling edge, so the data is visible to the read before the next rising edge.
- load_use = id_valid & ex_valid & ex_is_load & ex_rd_we & ex_rd hazardable & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)).
- stall = ex_hold | (load_use & !flush), combinational.
- Register update priority at each rising edge:
  1. reset: all ex_* and stall_cnt become 0.
  2. flush: ex_valid becomes 0; other fields don't-care.
  3. ex_hold: all ex_* hold their values.
  4. load_use: ex_valid becomes 0 (bubble); stall_cnt increments, saturating at 0xFFFF.
  5. Otherwise: load from id_* with the forwarded operands; ex_valid becomes id_valid.
- ex_op_b is the forwarded rs2 value. Immediate selection happens in EX.

## Timing
- Latency: 1 cycle from ID to the ex_* outputs.
- Load-use: exactly one bubble. On the following cycle the load is in MEM and mem_result supplies its data.
- flush with load_use in the same cycle: no stall, no count, bubble.
- ex_hold with flush in the same cycle: flush wins and ex_valid becomes 0. stall stays 1 because of ex_hold.
- Reset mid-operation: any in-flight instruction is dropped and ex_valid is 0 on the next cycle. stall follows ex_hold only.
- stall_cnt does not wrap.

## Structure
- Shared package `cpu_pkg`: DATA_W, REG_AW, OP_W, constants REG_PROT_LO=14, REG_PROT_HI=15, and the ALU opcode enum.
- Sub-module `operand_fwd_mux`: one per source. It takes rs, use, rf data and the EX/MEM sources, and returns the selected value.

## Test plan
- ALU chain: EX holds an ALU op writing R3 (alu_result=0x55). ID reads R3 on rs1. Required: ex_op_a=0x55 next cycle, no stall.
- Load-use: EX holds a load to R5; ID uses R5 on rs2. Required:
  - stall=1 for one cycle, then ex_valid=0 (bubble) and stall_cnt=1.
  - Next cycle, with mem_result=0xDEAD for R5: ex_op_b=0xDEAD.
- Priority: EX writes R2=0x11 and MEM writes R2=0x22. Required: operand=0x11. With EX invalid: 0x22.
- Protected regs: EX is a load to R14 and ID reads R14 (rf=14). Required: no stall, operand=14.
- Flush and hold:
  - flush together with load_use: ex_valid=0, stall=0, stall_cnt unchanged.
  - ex_hold for 3 cycles: ex_* frozen and stall=1.
- Reset: after random traffic, assert reset for 1 cycle. Required: all ex_*=0, stall_cnt=0, stall=ex_hold.
